// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and constants for the load/store sequencer
// Contents:
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD  access size encodings
//   state_t                          sequencer states
//   DEF_MEM_BASE/DEF_MEM_BYTES       default data-memory window
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam logic [31:0] DEF_MEM_BASE  = 32'h1001_0000;
  localparam logic [31:0] DEF_MEM_BYTES = 32'h0000_4000;

  // True when the byte offset is not a legal start for the given size.
  // The reserved size is reported separately, so it is never "misaligned".
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_HALF: misaligned = offset[0];
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane extract (loads) and lane merge (stores)
// Ports:
//   rword    in  32  word read from memory
//   wdata    in  32  right-justified store data
//   offset   in  2   byte offset within the word
//   size     in  2   access size encoding
//   sign_ext in  1   sign-extend the extracted lane
//   rdata    out 32  extracted and extended load data
//   merged   out 32  rword with the addressed lane(s) replaced by wdata
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rword[7:0];
    case (offset)
      2'd0: byte_lane = rword[7:0];
      2'd1: byte_lane = rword[15:8];
      2'd2: byte_lane = rword[23:16];
      2'd3: byte_lane = rword[31:24];
      default: byte_lane = rword[7:0];
    endcase
    half_lane = offset[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    rdata = rword;
    case (size)
      SZ_BYTE: rdata = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: rdata = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: rdata = rword;
    endcase
  end

  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: begin
        merged = rword;
        case (offset)
          2'd0: merged[7:0]   = wdata[7:0];
          2'd1: merged[15:8]  = wdata[7:0];
          2'd2: merged[23:16] = wdata[7:0];
          2'd3: merged[31:24] = wdata[7:0];
          default: merged = rword;
        endcase
      end
      SZ_HALF: begin
        merged = rword;
        if (offset[1]) merged[31:16] = wdata[15:0];
        else           merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store sequencer for a word-only data memory
// Ports:
//   clock, clear                 clock and synchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                    request fields
//   resp_valid, resp_rdata,
//   resp_error                   one-cycle completion
//   mem_address, mem_write,
//   mem_write_data,
//   mem_read_data                word memory interface (read is combinational)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
  parameter logic [31:0] MEM_BYTES = DEF_MEM_BYTES
)
(
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Window end computed in 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, MEM_BASE} + {1'b0, MEM_BYTES};

  state_t      state;
  logic [1:0]  offset_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic        err_q;
  logic [31:0] wdata_q;
  logic [31:0] rword;

  logic        req_err;
  logic [31:0] ext_rdata;
  logic [31:0] merged_word;

  always_comb begin
    req_err = (req_size == SZ_RSVD)
            || misaligned(req_size, req_addr[1:0])
            || (req_addr < MEM_BASE)
            || ({1'b0, req_addr} >= WIN_END);
  end

  mem_lane_align u_align (
    .rword    (rword),
    .wdata    (wdata_q),
    .offset   (offset_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .rdata    (ext_rdata),
    .merged   (merged_word)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= ST_IDLE;
      offset_q    <= 2'b00;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= 32'h0;
      rword       <= 32'h0;
      mem_address <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            offset_q <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            err_q    <= req_err;
            if (req_err) begin
              state <= ST_RESP;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              // Only full-word stores skip the read; everything else needs the old word.
              if (req_write && (req_size == SZ_WORD)) state <= ST_WRITE;
              else                                    state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          rword <= mem_read_data;
          state <= write_q ? ST_WRITE : ST_RESP;
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so they are settled
  // for the whole cycle before the memory's falling-edge write.
  assign req_ready      = (state == ST_IDLE) && !clear;
  assign mem_write      = (state == ST_WRITE);
  assign mem_write_data = (state == ST_WRITE) ? merged_word : 32'h0;
  assign resp_valid     = (state == ST_RESP);
  assign resp_error     = (state == ST_RESP) && err_q;
  assign resp_rdata     = ((state == ST_RESP) && !err_q && !write_q) ? ext_rdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clock = 1'b0;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_access_unit dut (
    .clock          (clock),
    .clear          (clear),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write      (mem_write),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // 16 KiB word memory at 0x1001_0000; the base is 16 KiB aligned so bits [13:2] index it.
  assign mem_read_data = (mem_address >= 32'h1001_0000 && mem_address < 32'h1001_4000)
                         ? mem[mem_address[13:2]] : 32'h0;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [0:17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Sample on the falling edge and perform the memory's falling-edge write.
  task automatic sample_cycle(output logic wr_seen, output logic [31:0] wr_addr);
    @(negedge clock);
    wr_seen = mem_write;
    wr_addr = mem_address;
    if (mem_write) mem[mem_address[13:2]] = mem_write_data;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat;
    int nwr;
    logic ws;
    logic [31:0] wa;
    logic [31:0] wr_addr;
    logic [31:0] got_rdata;
    logic        got_err;
    v = vecs[i];
    lat = 0;
    nwr = 0;
    wr_addr = 32'h0;
    got_rdata = 32'h0;
    got_err = 1'b0;
    @(negedge clock);
    if (v.pre) mem[v.addr[13:2]] = v.pre_word;
    req_valid  = 1'b1;
    req_write  = v.wr;
    req_size   = v.sz;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    chk($sformatf("v%0d ready", i), {31'b0, req_ready}, 32'h1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      sample_cycle(ws, wa);
      if (ws) begin
        nwr++;
        wr_addr = wa;
      end
      if (resp_valid) begin
        lat = k;
        got_rdata = resp_rdata;
        got_err = resp_error;
        break;
      end
      @(posedge clock);
    end
    @(posedge clock);
    chk($sformatf("v%0d latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d rdata", i), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d error", i), {31'b0, got_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d writes", i), nwr, (v.wr && !v.exp_err) ? 1 : 0);
    if (v.wr && !v.exp_err)
      chk($sformatf("v%0d wr_addr", i), wr_addr, {v.addr[31:2], 2'b00});
    if (v.chk_mem)
      chk($sformatf("v%0d mem", i), mem[v.addr[13:2]], v.exp_mem);
  endtask

  initial begin
    logic ws;
    logic [31:0] wa;
    int pulses;
    int nwr;

    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    //            wr  sz       sgn  addr           wdata          pre  pre_word       exp_rdata      err  lat chk  exp_mem
    vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h1001_0004, 32'h0,         1'b1, 32'h0000_00C8, 32'h0000_00C8, 1'b0, 2, 1'b1, 32'h0000_00C8};
    vecs[1]  = '{1'b0, SZ_BYTE, 1'b1, 32'h1001_0002, 32'h0,         1'b1, 32'h80FF_7F64, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, 32'h80FF_7F64};
    vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h1001_0003, 32'h0,         1'b0, 32'h0,         32'h0000_0080, 1'b0, 2, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h1001_0000, 32'h0,         1'b0, 32'h0,         32'h0000_0064, 1'b0, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, SZ_HALF, 1'b1, 32'h1001_0002, 32'h0,         1'b0, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'h0,         32'h0000_7F64, 1'b0, 2, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, SZ_HALF, 1'b0, 32'h1001_0002, 32'h0000_ABCD, 1'b1, 32'h1122_3344, 32'h0,         1'b0, 3, 1'b1, 32'hABCD_3344};
    vecs[7]  = '{1'b1, SZ_BYTE, 1'b0, 32'h1001_0001, 32'h0000_005A, 1'b1, 32'h1122_3344, 32'h0,         1'b0, 3, 1'b1, 32'h1122_5A44};
    vecs[8]  = '{1'b1, SZ_WORD, 1'b0, 32'h1001_0008, 32'hCAFE_F00D, 1'b1, 32'h0,         32'h0,         1'b0, 2, 1'b1, 32'hCAFE_F00D};
    vecs[9]  = '{1'b0, SZ_WORD, 1'b0, 32'h1001_0001, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, SZ_HALF, 1'b0, 32'h1001_0003, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, SZ_BYTE, 1'b1, 32'h1000_FFFF, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'h1001_4000, 32'h0,         1'b0, 32'h0,         32'h0,         1'b1, 1, 1'b0, 32'h0};
    vecs[13] = '{1'b1, SZ_RSVD, 1'b0, 32'h1001_0010, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 1, 1'b1, 32'h1234_5678};
    vecs[14] = '{1'b1, SZ_WORD, 1'b0, 32'h1001_3FFC, 32'hDEAD_BEEF, 1'b1, 32'h0,         32'h0,         1'b0, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, SZ_WORD, 1'b1, 32'h1001_3FFC, 32'h0,         1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[16] = '{1'b1, SZ_BYTE, 1'b0, 32'h1001_3FFF, 32'h0000_00AA, 1'b0, 32'h0,         32'h0,         1'b0, 3, 1'b1, 32'hAAAD_BEEF};
    vecs[17] = '{1'b0, SZ_BYTE, 1'b1, 32'h1001_3FFF, 32'h0,         1'b0, 32'h0,         32'hFFFF_FFAA, 1'b0, 2, 1'b0, 32'h0};

    clear = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = SZ_WORD;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset ready_during_clear", {31'b0, req_ready}, 32'h0);
    clear = 1'b0;
    @(negedge clock);
    chk("reset ready", {31'b0, req_ready}, 32'h1);
    chk("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("reset mem_write", {31'b0, mem_write}, 32'h0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset mem_write_data", mem_write_data, 32'h0);
    chk("reset resp_rdata", resp_rdata, 32'h0);

    for (int i = 0; i < 18; i++) run_vec(i);

    // Request held high: the busy cycles ignore it, the next handshake lands right after RESP.
    @(negedge clock);
    mem[12'h001] = 32'h0000_00C8;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = SZ_WORD;
    req_signed = 1'b0;
    req_addr = 32'h1001_0004;
    @(posedge clock);
    pulses = 0;
    nwr = 0;
    for (int k = 1; k <= 5; k++) begin
      sample_cycle(ws, wa);
      if (ws) nwr++;
      if (resp_valid) begin
        pulses++;
        chk($sformatf("b2b resp_k%0d", k), k, (pulses == 1) ? 2 : 5);
        chk($sformatf("b2b rdata_k%0d", k), resp_rdata, 32'h0000_00C8);
      end
      if (k == 1) chk("b2b ready_busy", {31'b0, req_ready}, 32'h0);
      if (k == 3) chk("b2b ready_after_resp", {31'b0, req_ready}, 32'h1);
      if (k == 5) req_valid = 1'b0;
      @(posedge clock);
    end
    chk("b2b pulses", pulses, 2);
    chk("b2b writes", nwr, 0);

    // Clear during the READ cycle of a byte store: access dropped, memory untouched.
    @(negedge clock);
    mem[12'h003] = 32'h1122_3344;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = SZ_BYTE;
    req_signed = 1'b0;
    req_addr = 32'h1001_000D;
    req_wdata = 32'h0000_0099;
    @(posedge clock);
    #1 req_valid = 1'b0;
    sample_cycle(ws, wa);
    chk("rst_mid read_cycle_mem_address", mem_address, 32'h1001_000C);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    pulses = 0;
    nwr = 0;
    for (int k = 1; k <= 4; k++) begin
      sample_cycle(ws, wa);
      if (ws) nwr++;
      if (resp_valid) pulses++;
      if (k == 1) begin
        chk("rst_mid ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mid mem_write", {31'b0, mem_write}, 32'h0);
        chk("rst_mid mem_address", mem_address, 32'h0);
      end
      @(posedge clock);
    end
    chk("rst_mid resp_pulses", pulses, 0);
    chk("rst_mid writes", nwr, 0);
    chk("rst_mid mem", mem[12'h003], 32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator-side load/store sequencer between the processor datapath and the word-only data memory. It accepts one byte, halfword or word access at a time and drives the memory's address, write strobe and write data. It returns aligned, extended load data. Sub-word stores are done as a read-modify-write, because the memory only writes full words.

Parameters:
MEM_BASE, 32'h10010000, first valid byte address of data memory
MEM_BYTES, 32'h00004000, size of the valid window in bytes; the valid range is [MEM_BASE, MEM_BASE+MEM_BYTES)

Ports:
clock  in  1  system clock; all state updates on the rising edge
clear  in  1  synchronous active-high reset
req_valid  in  1  access request present
req_ready  out  1  unit can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (flags an error)
req_signed  in  1  load sign-extends when 1, zero-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  misaligned, out-of-window or reserved-size access
mem_address  out  32  word-aligned address to memory (bits [1:0] = 00)
mem_write  out  1  memory write enable
mem_write_data  out  32  word written to memory
mem_read_data  in  32  memory read word; combinational from mem_address

Behaviour:
- Reset and ready:
  - clear is sampled on the rising edge of clock. It forces IDLE and clears all outputs and internal registers to 0.
  - req_ready = (state==IDLE) && !clear.
- States: IDLE, READ, WRITE, RESP.
  - All memory-side outputs are registered or decoded from registered state only. They are stable for the whole cycle, so the memory's falling-edge write sees settled values.
- IDLE:
  - Handshake is req_valid && req_ready. On handshake, latch addr, size, signed, write and wdata.
  - Error if any of: size==11; half with addr[0]==1; word with addr[1:0]!=0; addr < MEM_BASE; addr >= MEM_BASE+MEM_BYTES. An error goes to RESP with no memory access.
  - Otherwise: load goes to READ; word store goes to WRITE; byte or half store goes to READ.
- READ:
  - mem_address = {addr[31:2],2'b00}, mem_write=0. Capture mem_read_data into rword.
  - Load goes to RESP. Sub-word store goes to WRITE.
- WRITE:
  - mem_write=1, mem_address aligned as in READ.
  - mem_write_data: word store uses wdata. Byte store replaces lane addr[1:0] of rword with wdata[7:0]. Half store replaces lane addr[1] of rword with wdata[15:0].
  - Lanes are little-endian: byte lane k = bits [8k+7:8k].
  - Next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_error and resp_rdata are valid with it.
  - resp_rdata on loads: lane selected from rword, sign- or zero-extended to 32 bits per req_signed. Word loads ignore req_signed.
  - Next state IDLE. There is no response backpressure.
- Latency, with the handshake at edge N:
  - error: resp at N+1
  - load: resp at N+2
  - word store: resp at N+2
  - sub-word store: resp at N+3
- Outside WRITE, mem_write=0. Outside READ and WRITE, mem_address holds its last value (0 after reset).
- Boundaries:
  - req_valid while not IDLE is ignored, not queued.
  - Address MEM_BASE+MEM_BYTES-4 is valid for word access. MEM_BASE+MEM_BYTES is an error.
  - Address arithmetic is unsigned 32-bit; there is no wrap beyond 2^32.
- Reset mid-operation: clear in READ or WRITE returns the unit to IDLE at that edge. mem_write is low from that edge, no response is issued, and the pending access is dropped. A store partially performed before clear is not rolled back.
- Back-to-back: the earliest a new handshake can occur is the cycle after RESP, because IDLE is re-entered at that edge.

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - state enum
  - default window constants
- One combinational sub-module, mem_lane_align, does both halves of the lane work:
  - extract: rword, offset, size, signed -> rdata
  - merge: rword, wdata, offset, size -> merged word

Test Plan:
- Word load, memory word at 0x10010004 = 0x000000C8, req_addr=0x10010004, size word -> resp_valid 2 cycles after handshake, rdata=0x000000C8, error=0, mem_write never high.
- Signed and unsigned byte load, word at 0x10010000 = 0x80FF7F64:
  - addr 0x10010002, signed=1 -> rdata 0xFFFFFFFF
  - addr 0x10010003, signed=0 -> rdata 0x00000080
  - addr 0x10010000 -> 0x00000064
- Half store, word = 0x11223344, addr 0x10010002, wdata 0x0000ABCD -> one READ then one WRITE cycle with mem_write_data=0xABCD3344; resp at N+3, error=0.
- Errors, each giving resp at N+1 with error=1, rdata=0 and no mem_write:
  - word at 0x10010001
  - half at 0x10010003
  - byte at 0x1000FFFF
  - word at 0x10014000
  - size=11
- Window edge: word store at 0x10013FFC, data 0xDEADBEEF -> WRITE at N+1 with mem_address=0x10013FFC. Then a load from the same address -> 0xDEADBEEF.
- Reset during a byte store: clear asserted in the READ cycle -> next cycle IDLE, req_ready=1, mem_write=0, no resp_valid, memory word unchanged.
